// File: rtl/colour_scan_ctrl.sv
// colour_scan_ctrl
// Sequences a colour-sensor scan. It steps the photodiode filter through red,
// blue, green (and, optionally, clear). After each filter change it waits for
// the sensor to settle, then measures one high pulse of the sensor output in
// clk cycles.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   start        one-cycle scan request, honoured only when idle
//   colour_freq  asynchronous sensor square wave
//   ready        consumer accepts the result while valid is high
//   s2, s3       sensor filter select
//   busy         scan accepted and result not yet taken
//   valid        result available (counts and timeout stable while high)
//   red_cnt, blue_cnt, green_cnt, clear_cnt  high-pulse widths in clk cycles
//   timeout      per-channel timeout flags {clear, green, blue, red}
//
// Build option
//   COLOUR_SCAN_CLEAR_EN  when defined, the clear channel (s2=1, s3=0) is
//                         scanned fourth. Otherwise clear_cnt and timeout[3]
//                         are tied to 0.
//
// State table
//   IDLE    | waiting for start
//   SETTLE  | filter just changed, waiting SETTLE_CYC cycles
//   ARM     | waiting for a synchronized rising edge (timeout running)
//   MEASURE | counting high cycles until the falling edge (timeout running)
//   NEXT    | pick the next channel or finish
//   DONE    | valid high, waiting for ready
module colour_scan_ctrl #(
  parameter int SETTLE_CYC  = 500,
  parameter int TIMEOUT_CYC = 60000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             colour_freq,
  input  logic             ready,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [3:0]       timeout
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

`ifdef COLOUR_SCAN_CLEAR_EN
  localparam int         NCH     = 4;
  localparam logic [1:0] LAST_CH = 2'd3;
`else
  localparam int         NCH     = 3;
  localparam logic [1:0] LAST_CH = 2'd2;
`endif

  typedef enum logic [2:0] {IDLE, SETTLE, ARM, MEASURE, NEXT, DONE} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, freq_s_q, freq_d_q;
  logic               rise, fall;
  logic [1:0]         ch_q;
  logic [SET_W-1:0]   settle_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [CNT_W-1:0]   width_q;
  logic [NCH-1:0]     tout_q;
  logic               accept, advance, arm_entry, got_rise, got_fall, tmo_hit;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_val;

  // Filter code for each channel index: red, blue, green, clear.
  function automatic logic [1:0] filt(input logic [1:0] ch);
    case (ch)
      2'd0:    filt = 2'b00;
      2'd1:    filt = 2'b01;
      2'd2:    filt = 2'b11;
      default: filt = 2'b10;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      freq_s_q <= 1'b0;
      freq_d_q <= 1'b0;
    end else begin
      sync1_q  <= colour_freq;
      freq_s_q <= sync1_q;
      freq_d_q <= freq_s_q;
    end
  end

  assign rise = freq_s_q & ~freq_d_q;
  assign fall = ~freq_s_q & freq_d_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    advance   = 1'b0;
    arm_entry = 1'b0;
    got_rise  = 1'b0;
    got_fall  = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          arm_entry = 1'b1;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (tmo_q == '0) begin
          tmo_hit = 1'b1;
          state_d = NEXT;
        end else if (rise) begin
          got_rise = 1'b1;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        // A completed pulse wins over a timeout landing on the same cycle.
        if (fall) begin
          got_fall = 1'b1;
          state_d  = NEXT;
        end else if (tmo_q == '0) begin
          tmo_hit = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (ch_q == LAST_CH) begin
          state_d = DONE;
        end else begin
          advance = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign valid  = (state_q == DONE);
  assign wr_en  = got_fall | tmo_hit;
  assign wr_val = tmo_hit ? '1 : width_q;

  // Filter select changes on the same edge that enters SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= 2'd0;
      s2   <= 1'b0;
      s3   <= 1'b0;
    end else if (accept) begin
      ch_q     <= 2'd0;
      {s2, s3} <= filt(2'd0);
    end else if (advance) begin
      ch_q     <= ch_q + 2'd1;
      {s2, s3} <= filt(ch_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= '0;
      tmo_q    <= '0;
      width_q  <= '0;
    end else begin
      if (accept || advance)
        settle_q <= SET_W'(SETTLE_CYC - 1);
      else if (state_q == SETTLE && settle_q != '0)
        settle_q <= settle_q - 1'b1;

      if (arm_entry)
        tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
      else if ((state_q == ARM || state_q == MEASURE) && tmo_q != '0)
        tmo_q <= tmo_q - 1'b1;

      // The rising-edge cycle is already a high cycle, so the width starts at 1.
      if (got_rise)
        width_q <= CNT_W'(1);
      else if (state_q == MEASURE && freq_s_q && width_q != '1)
        width_q <= width_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_cnt   <= '0;
      blue_cnt  <= '0;
      green_cnt <= '0;
`ifdef COLOUR_SCAN_CLEAR_EN
      clear_cnt <= '0;
`endif
      tout_q    <= '0;
    end else begin
      if (accept) tout_q <= '0;
      if (wr_en) begin
        case (ch_q)
          2'd0: begin red_cnt   <= wr_val; if (tmo_hit) tout_q[0] <= 1'b1; end
          2'd1: begin blue_cnt  <= wr_val; if (tmo_hit) tout_q[1] <= 1'b1; end
          2'd2: begin green_cnt <= wr_val; if (tmo_hit) tout_q[2] <= 1'b1; end
`ifdef COLOUR_SCAN_CLEAR_EN
          2'd3: begin clear_cnt <= wr_val; if (tmo_hit) tout_q[3] <= 1'b1; end
`endif
          default: ;
        endcase
      end
    end
  end

`ifndef COLOUR_SCAN_CLEAR_EN
  assign clear_cnt = '0;
`endif
  assign timeout = 4'(tout_q);

endmodule

// File: tb/tb_colour_scan_ctrl.sv
// Bench for colour_scan_ctrl. A sensor model drives colour_freq with a square
// wave whose high/low widths depend on the selected filter, and it restarts
// the wave whenever the filter changes or a scan starts. Expected counts come
// straight from the programmed high widths: 0 means stuck low, which gives an
// all-ones count and a timeout flag.
module tb_colour_scan_ctrl;
  localparam int SETTLE   = 4;
  localparam int TMO      = 100;
  localparam int CW       = 16;
  localparam int MAX_WAIT = 3000;
`ifdef COLOUR_SCAN_CLEAR_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif

  logic          clk, rst, start, colour_freq, ready;
  logic          s2, s3, busy, valid;
  logic [CW-1:0] red_cnt, blue_cnt, green_cnt, clear_cnt;
  logic [3:0]    timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_w[4];
  int lo_w[4];
  int sens_req = 0;
  logic [1:0] seq[$];
  logic prev_busy = 1'b0;

  colour_scan_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .colour_freq(colour_freq), .ready(ready),
    .s2(s2), .s3(s3), .busy(busy), .valid(valid),
    .red_cnt(red_cnt), .blue_cnt(blue_cnt), .green_cnt(green_cnt), .clear_cnt(clear_cnt),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sel2ch(input logic [1:0] sel);
    case (sel)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ch2sel(input int ch);
    case (ch)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [CW-1:0] dut_cnt(input int ch);
    case (ch)
      0:       return red_cnt;
      1:       return blue_cnt;
      2:       return green_cnt;
      default: return clear_cnt;
    endcase
  endfunction

  // Reference model: one pulse width per channel, stuck-low saturates.
  function automatic int exp_cnt(input int ch);
    return (hi_w[ch] == 0) ? ((1 << CW) - 1) : hi_w[ch];
  endfunction

  function automatic logic [3:0] exp_tout();
    logic [3:0] t;
    t = 4'b0000;
    for (int c = 0; c < NCH; c++) if (hi_w[c] == 0) t[c] = 1'b1;
    return t;
  endfunction

  // Sensor model
  initial begin : sensor
    logic [1:0] last;
    int ph, c, seen;
    last = 2'b00; ph = 0; seen = 0; colour_freq = 1'b0;
    forever begin
      @(posedge clk); #1;
      if ({s2, s3} !== last || seen != sens_req) begin
        last = {s2, s3}; seen = sens_req; ph = 0; colour_freq = 1'b0;
      end else begin
        c = sel2ch(last);
        if (hi_w[c] == 0) colour_freq = 1'b0;
        else begin
          ph++;
          if (ph > lo_w[c] + hi_w[c]) ph = 1;
          colour_freq = (ph > lo_w[c]);
        end
      end
    end
  end

  // Filter-select history for the current scan.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (prev_busy !== 1'b1) seq.delete();
      if (seq.size() == 0 || seq[$] !== {s2, s3}) seq.push_back({s2, s3});
    end
    prev_busy <= busy;
  end

  task automatic run_scan(output bit hung);
    int cyc;
    @(negedge clk); start = 1'b1; sens_req++;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (valid !== 1'b1 && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    hung = (valid !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, valid, s2, s3, timeout, red_cnt, blue_cnt, green_cnt, clear_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b s2s3=%b%b tmo=%h r=%0d b=%0d g=%0d c=%0d, expected all 0",
               busy, valid, s2, s3, timeout, red_cnt, blue_cnt, green_cnt, clear_cnt);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if ({busy, valid, s2, s3, timeout, red_cnt, blue_cnt, green_cnt, clear_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_release: busy=%b valid=%b s2s3=%b%b tmo=%h, expected all 0", busy, valid, s2, s3, timeout);
      end
    end
  endtask

  task automatic test_basic();
    bit hung, bad;
    int d;
    logic [4*CW+3:0] snap;
    hi_w = '{10, 20, 30, 40}; lo_w = '{5, 6, 7, 8};
    run_scan(hung);
    n_tests++;
    if (hung) begin n_fail++; $display("FAIL basic_done: valid=%b, expected 1 within %0d cycles", valid, MAX_WAIT); end
    for (int c = 0; c < NCH; c++) begin
      d = int'(dut_cnt(c)) - exp_cnt(c);
      n_tests++;
      if (d < -1 || d > 1) begin
        n_fail++; $display("FAIL basic_cnt%0d: got %0d expected %0d+-1", c, dut_cnt(c), exp_cnt(c));
      end
    end
    n_tests++;
    if (timeout !== exp_tout()) begin n_fail++; $display("FAIL basic_timeout: got %b expected %b", timeout, exp_tout()); end
`ifndef COLOUR_SCAN_CLEAR_EN
    n_tests++;
    if (clear_cnt !== '0) begin n_fail++; $display("FAIL basic_clear_tied: got %0d expected 0", clear_cnt); end
`endif
    bad = (seq.size() != NCH);
    for (int c = 0; c < NCH && !bad; c++) if (seq[c] !== ch2sel(c)) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL basic_filter_seq: got %0d entries, expected %0d in order 00,01,11,10", seq.size(), NCH); end
    snap = {red_cnt, blue_cnt, green_cnt, clear_cnt, timeout};
    repeat (50) begin
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b1 || busy !== 1'b1 || {red_cnt, blue_cnt, green_cnt, clear_cnt, timeout} !== snap) begin
        n_fail++; $display("FAIL hold_stable: valid=%b busy=%b outputs=%h expected valid=1 busy=1 outputs=%h",
                           valid, busy, {red_cnt, blue_cnt, green_cnt, clear_cnt, timeout}, snap);
      end
    end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    n_tests++;
    if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_handshake: valid=%b busy=%b expected 0 0", valid, busy); end
  endtask

  task automatic test_timeout_blue();
    bit hung;
    int d, cyc;
    hi_w = '{12, 0, 25, 18}; lo_w = '{4, 6, 5, 7};
    run_scan(hung);
    n_tests++;
    if (hung) begin n_fail++; $display("FAIL tmo_done: valid=%b, expected 1", valid); end
    n_tests++;
    if (blue_cnt !== 16'hFFFF || timeout !== exp_tout()) begin
      n_fail++; $display("FAIL tmo_blue: blue=%h tmo=%b expected ffff %b", blue_cnt, timeout, exp_tout());
    end
    for (int c = 0; c < NCH; c += 2) begin
      d = int'(dut_cnt(c)) - exp_cnt(c);
      n_tests++;
      if (d < -1 || d > 1) begin n_fail++; $display("FAIL tmo_cnt%0d: got %0d expected %0d+-1", c, dut_cnt(c), exp_cnt(c)); end
    end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    n_tests++;
    if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL tmo_handshake: valid=%b busy=%b expected 0 0", valid, busy); end
    // New scan: flags clear at acceptance, counts stay until overwritten.
    hi_w[1] = 15;
    @(negedge clk); start = 1'b1; sens_req++;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || timeout !== 4'b0000 || blue_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL flags_clear: busy=%b tmo=%b blue=%h expected 1 0000 ffff", busy, timeout, blue_cnt);
    end
    cyc = 0;
    while (valid !== 1'b1 && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    d = int'(blue_cnt) - 15;
    n_tests++;
    if (valid !== 1'b1 || d < -1 || d > 1 || timeout !== 4'b0000) begin
      n_fail++; $display("FAIL rescan_blue: valid=%b blue=%0d tmo=%b expected 1 15+-1 0000", valid, blue_cnt, timeout);
    end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bit bad;
    int d, cyc;
    hi_w = '{14, 22, 9, 33}; lo_w = '{4, 9, 6, 5};
    @(negedge clk); start = 1'b1; sens_req++;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (valid !== 1'b1 && cyc < MAX_WAIT) begin
      start = (cyc % 37 == 5);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL swb_done: valid=%b expected 1", valid); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL swb_in_done: valid=%b busy=%b expected 1 1", valid, busy); end
    bad = (seq.size() != NCH);
    for (int c = 0; c < NCH && !bad; c++) if (seq[c] !== ch2sel(c)) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL swb_filter_seq: got %0d entries expected %0d in order", seq.size(), NCH); end
    for (int c = 0; c < NCH; c++) begin
      d = int'(dut_cnt(c)) - exp_cnt(c);
      n_tests++;
      if (d < -1 || d > 1) begin n_fail++; $display("FAIL swb_cnt%0d: got %0d expected %0d+-1", c, dut_cnt(c), exp_cnt(c)); end
    end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL swb_idle: valid=%b busy=%b expected 0 0", valid, busy); end
  endtask

  task automatic test_ready_early();
    bit hung;
    int d;
    hi_w = '{7, 11, 19, 26}; lo_w = '{3, 8, 4, 6};
    ready = 1'b1;
    run_scan(hung);
    n_tests++;
    if (hung) begin n_fail++; $display("FAIL early_done: valid=%b expected 1", valid); end
    @(negedge clk);
    ready = 1'b0;
    n_tests++;
    if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL early_handshake: valid=%b busy=%b expected 0 0", valid, busy); end
    for (int c = 0; c < NCH; c++) begin
      d = int'(dut_cnt(c)) - exp_cnt(c);
      n_tests++;
      if (d < -1 || d > 1) begin n_fail++; $display("FAIL early_cnt_kept%0d: got %0d expected %0d+-1", c, dut_cnt(c), exp_cnt(c)); end
    end
  endtask

  task automatic test_random();
    bit hung, bad;
    int d;
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 4; c++) begin
        hi_w[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 60));
        lo_w[c] = int'($urandom_range(3, 12));
      end
      run_scan(hung);
      n_tests++;
      if (hung) begin n_fail++; $display("FAIL rand%0d_done: valid=%b expected 1", it, valid); end
      for (int c = 0; c < NCH; c++) begin
        d = int'(dut_cnt(c)) - exp_cnt(c);
        bad = (hi_w[c] == 0) ? (d != 0) : (d < -1 || d > 1);
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL rand%0d_cnt%0d: got %0d expected %0d (hi=%0d)", it, c, dut_cnt(c), exp_cnt(c), hi_w[c]); end
      end
      n_tests++;
      if (timeout !== exp_tout()) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected %b", it, timeout, exp_tout()); end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      ready = 1'b1; @(negedge clk); ready = 1'b0;
      n_tests++;
      if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rand%0d_handshake: valid=%b busy=%b expected 0 0", it, valid, busy); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    hi_w = '{10, 20, 30, 40}; lo_w = '{5, 6, 7, 8};
    @(negedge clk); start = 1'b1; sens_req++;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while ({s2, s3} !== 2'b11 && cyc < MAX_WAIT) begin @(negedge clk); cyc++; end
    n_tests++;
    if ({s2, s3} !== 2'b11) begin n_fail++; $display("FAIL rstmid_green: s2s3=%b%b expected 11", s2, s3); end
    repeat (SETTLE + lo_w[2] + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, valid, s2, s3, timeout, red_cnt, blue_cnt, green_cnt, clear_cnt} !== '0) begin
      n_fail++; $display("FAIL rstmid_clear: busy=%b valid=%b s2s3=%b%b r=%0d b=%0d g=%0d expected all 0",
                         busy, valid, s2, s3, red_cnt, blue_cnt, green_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, valid, s2, s3} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_idle: busy=%b valid=%b s2s3=%b%b expected 0", busy, valid, s2, s3); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    for (int c = 0; c < 4; c++) begin hi_w[c] = 0; lo_w[c] = 5; end
    test_reset();
    test_basic();
    test_timeout_blue();
    test_start_while_busy();
    test_ready_early();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
